// File: rtl/dcache_pkg.sv
// Shared types and helpers for the set-associative data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WB      = 2'd1,
        FILL    = 2'd2,
        FILL_OK = 2'd3
    } state_e;

    localparam int unsigned REPLACE_FIFO = 0;
    localparam int unsigned REPLACE_LRU  = 1;

    // Replace only the bytes of old_w whose enable bit is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_repl.sv
// Per-set replacement state: LRU ages or FIFO pointer, selected by REPLACE_POLICY.
module dcache_repl
    import dcache_pkg::*;
#(
    parameter int unsigned REPLACE_POLICY = REPLACE_LRU,
    parameter int unsigned SET_ADDR_LEN   = 3,
    parameter int unsigned WAY_ADDR_LEN   = 2,
    localparam int unsigned WAY_W         = (WAY_ADDR_LEN > 0) ? WAY_ADDR_LEN : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SET_ADDR_LEN-1:0] set_i,
    input  logic                    touch_i,
    input  logic [WAY_W-1:0]        touch_way_i,
    input  logic                    fill_i,
    output logic [WAY_W-1:0]        victim_c_o
);

    localparam int unsigned SETS = 1 << SET_ADDR_LEN;
    localparam int unsigned WAYS = 1 << WAY_ADDR_LEN;

    if (REPLACE_POLICY == REPLACE_LRU) begin : g_lru
        logic [WAY_W-1:0] age_q [SETS][WAYS];
        logic [WAY_W-1:0] ref_age;

        // A fill is treated as touching a way of maximal age; this grows the
        // per-set permutation out of the all-zero reset state.
        always_comb begin
            ref_age = age_q[set_i][touch_way_i];
            if (fill_i) ref_age = WAY_W'(WAYS - 1);
        end

        // Age update: younger ways move back one step, the touched way becomes MRU.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++)
                        age_q[s][w] <= '0;
            end else if (touch_i) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == touch_way_i)
                        age_q[set_i][w] <= '0;
                    else if (age_q[set_i][w] < ref_age)
                        age_q[set_i][w] <= age_q[set_i][w] + WAY_W'(1);
                end
            end
        end

        // Victim is the oldest way of the addressed set.
        always_comb begin
            victim_c_o = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[set_i][w] == WAY_W'(WAYS - 1)) victim_c_o = WAY_W'(w);
            end
        end
    end else begin : g_fifo
        logic [WAY_W-1:0] ptr_q [SETS];
        logic             unused_touch;

        assign unused_touch = ^{touch_i, touch_way_i};

        // Round-robin pointer advances on fills only.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
            end else if (fill_i) begin
                ptr_q[set_i] <= (WAYS == 1) ? '0 : ptr_q[set_i] + WAY_W'(1);
            end
        end

        assign victim_c_o = ptr_q[set_i];
    end

endmodule

// File: rtl/set_assoc_dcache.sv
// Write-back, write-allocate N-way set-associative data cache.
// Optional performance counters are built when DCACHE_PERF_CNT_EN is defined.
module set_assoc_dcache
    import dcache_pkg::*;
#(
    parameter int unsigned REPLACE_POLICY = REPLACE_LRU,
    parameter int unsigned LINE_ADDR_LEN  = 3,
    parameter int unsigned SET_ADDR_LEN   = 3,
    parameter int unsigned TAG_ADDR_LEN   = 6,
    parameter int unsigned WAY_ADDR_LEN   = 2,
    localparam int unsigned MEM_ADDR_LEN  = TAG_ADDR_LEN + SET_ADDR_LEN,
    localparam int unsigned LINE_W        = 32 * (1 << LINE_ADDR_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             addr,
    input  logic                    rd_req,
    input  logic                    wr_req,
    input  logic [3:0]              wr_be,
    input  logic [31:0]             wr_data,
    output logic [31:0]             rd_data,
    output logic                    miss,
    output logic                    mem_rd_req,
    output logic                    mem_wr_req,
    output logic [MEM_ADDR_LEN-1:0] mem_addr,
    output logic [LINE_W-1:0]       mem_wr_line,
    input  logic [LINE_W-1:0]       mem_rd_line,
    input  logic                    mem_gnt,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
);

    localparam int unsigned WORDS    = 1 << LINE_ADDR_LEN;
    localparam int unsigned SETS     = 1 << SET_ADDR_LEN;
    localparam int unsigned WAYS     = 1 << WAY_ADDR_LEN;
    localparam int unsigned WAY_W    = (WAY_ADDR_LEN > 0) ? WAY_ADDR_LEN : 1;
    localparam int unsigned ADDR_TOP = 2 + LINE_ADDR_LEN + SET_ADDR_LEN + TAG_ADDR_LEN;

    logic [LINE_ADDR_LEN-1:0] word_idx;
    logic [SET_ADDR_LEN-1:0]  set_idx;
    logic [TAG_ADDR_LEN-1:0]  tag_in;
    logic                     unused_addr_bits;

    assign word_idx         = addr[2 +: LINE_ADDR_LEN];
    assign set_idx          = addr[2 + LINE_ADDR_LEN +: SET_ADDR_LEN];
    assign tag_in           = addr[2 + LINE_ADDR_LEN + SET_ADDR_LEN +: TAG_ADDR_LEN];
    assign unused_addr_bits = ^{addr[31:ADDR_TOP], addr[1:0]};

    logic [31:0]             data_q  [SETS][WAYS][WORDS];
    logic [TAG_ADDR_LEN-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]         valid_q [SETS];
    logic [WAYS-1:0]         dirty_q [SETS];

    state_e                  state_q;
    logic [WAY_W-1:0]        victim_way_q;
    logic [TAG_ADDR_LEN-1:0] req_tag_q;
    logic [SET_ADDR_LEN-1:0] req_set_q;
    logic [LINE_W-1:0]       fill_line_q;

    logic                    req, idle, hit, hit_access, commit;
    logic [WAY_W-1:0]        hit_way, victim_way, repl_victim;
    logic [LINE_W-1:0]       victim_line;

    assign req        = rd_req | wr_req;
    assign idle       = (state_q == IDLE);
    assign miss       = req & ~(hit & idle);
    assign hit_access = req & hit & idle;
    assign commit     = (state_q == FILL_OK);

    // Tag match across the ways of the addressed set.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag_in) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, else the replacement policy's choice.
    always_comb begin
        logic found;
        found      = 1'b0;
        victim_way = repl_victim;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[set_idx][w]) begin
                found      = 1'b1;
                victim_way = WAY_W'(w);
            end
        end
        for (int i = 0; i < WORDS; i++)
            victim_line[32*i +: 32] = data_q[set_idx][victim_way][i];
    end

    dcache_repl #(
        .REPLACE_POLICY (REPLACE_POLICY),
        .SET_ADDR_LEN   (SET_ADDR_LEN),
        .WAY_ADDR_LEN   (WAY_ADDR_LEN)
    ) u_repl (
        .clk         (clk),
        .rst         (rst),
        .set_i       (commit ? req_set_q : set_idx),
        .touch_i     (hit_access | commit),
        .touch_way_i (commit ? victim_way_q : hit_way),
        .fill_i      (commit),
        .victim_c_o  (repl_victim)
    );

    // Miss-handling FSM with registered memory-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mem_rd_req   <= 1'b0;
            mem_wr_req   <= 1'b0;
            mem_addr     <= '0;
            mem_wr_line  <= '0;
            victim_way_q <= '0;
            req_tag_q    <= '0;
            req_set_q    <= '0;
            fill_line_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (req && !hit) begin
                    victim_way_q <= victim_way;
                    req_tag_q    <= tag_in;
                    req_set_q    <= set_idx;
                    if (valid_q[set_idx][victim_way] && dirty_q[set_idx][victim_way]) begin
                        state_q     <= WB;
                        mem_wr_req  <= 1'b1;
                        mem_addr    <= {tag_q[set_idx][victim_way], set_idx};
                        mem_wr_line <= victim_line;
                    end else begin
                        state_q    <= FILL;
                        mem_rd_req <= 1'b1;
                        mem_addr   <= {tag_in, set_idx};
                    end
                end
                WB: if (mem_gnt) begin
                    state_q     <= FILL;
                    mem_wr_req  <= 1'b0;
                    mem_wr_line <= '0;
                    mem_rd_req  <= 1'b1;
                    mem_addr    <= {req_tag_q, req_set_q};
                end
                FILL: if (mem_gnt) begin
                    state_q     <= FILL_OK;
                    mem_rd_req  <= 1'b0;
                    mem_addr    <= '0;
                    fill_line_q <= mem_rd_line;
                end
                FILL_OK: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data and tag arrays: line install on commit, byte-merged store on hit.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < WORDS; i++)
                data_q[req_set_q][victim_way_q][i] <= fill_line_q[32*i +: 32];
            tag_q[req_set_q][victim_way_q] <= req_tag_q;
        end else if (idle && wr_req && hit) begin
            data_q[set_idx][hit_way][word_idx] <=
                merge_bytes(data_q[set_idx][hit_way][word_idx], wr_data, wr_be);
        end
    end

    // Valid/dirty bits: installed lines start clean, stores with any byte enabled dirty them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else if (commit) begin
            valid_q[req_set_q][victim_way_q] <= 1'b1;
            dirty_q[req_set_q][victim_way_q] <= 1'b0;
        end else if (idle && wr_req && hit && (|wr_be)) begin
            dirty_q[set_idx][hit_way] <= 1'b1;
        end
    end

    // Load data register; a simultaneous store takes priority and leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else if (idle && rd_req && !wr_req && hit) rd_data <= data_q[set_idx][hit_way][word_idx];
    end

`ifdef DCACHE_PERF_CNT_EN
    // Hit cycles and miss entries, free-running with natural wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_access)           hit_cnt  <= hit_cnt + 32'd1;
            if (idle && req && !hit)  miss_cnt <= miss_cnt + 32'd1;
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_set_assoc_dcache.sv
// Directed bench for set_assoc_dcache with default geometry (4 ways, 8 sets, 8-word lines, LRU).
module tb_set_assoc_dcache;

    logic         clk, rst;
    logic [31:0]  addr, wr_data, rd_data, hit_cnt, miss_cnt;
    logic         rd_req, wr_req, miss, mem_rd_req, mem_wr_req, mem_gnt;
    logic [3:0]   wr_be;
    logic [8:0]   mem_addr;
    logic [255:0] mem_wr_line, mem_rd_line;

    int checks = 0;
    int errors = 0;

    logic         first_miss, wb_seen, fill_seen;
    logic [8:0]   wb_addr, fill_addr;
    logic [255:0] wb_line, exp_line;
    logic [31:0]  exp_hits, exp_misses;

    set_assoc_dcache #(.REPLACE_POLICY(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .wr_be       (wr_be),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .miss        (miss),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .mem_wr_line (mem_wr_line),
        .mem_rd_line (mem_rd_line),
        .mem_gnt     (mem_gnt),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    // Backing-memory content: word i of line la = 0xD0000000 | la<<8 | i.
    function automatic logic [255:0] line_of(input logic [8:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'hD000_0000 | (32'(la) << 8) | 32'(i);
        return l;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One core access held until miss drops; serves WB/FILL with an optional grant delay.
    task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [3:0] be, input logic [31:0] d,
                          input int gnt_delay, input bit check_stable);
        int cyc;
        int wait_n;
        @(negedge clk);
        addr = a; rd_req = rd; wr_req = wr; wr_be = be; wr_data = d;
        #1;
        first_miss = miss; wb_seen = 0; fill_seen = 0; cyc = 0; wait_n = 0;
        while (miss === 1'b1 && cyc < 200) begin
            if (mem_wr_req && !wb_seen) begin wb_seen = 1; wb_addr = mem_addr; wb_line = mem_wr_line; end
            if (mem_rd_req && !fill_seen) begin fill_seen = 1; fill_addr = mem_addr; end
            if (mem_wr_req || mem_rd_req) begin
                if (wait_n >= gnt_delay) begin
                    mem_gnt = 1; mem_rd_line = line_of(mem_addr); wait_n = 0;
                end else begin
                    if (check_stable) begin
                        chk("stall_miss", miss, 1'b1);
                        chk("stall_rd_req", mem_rd_req, 1'b1);
                        chk("stall_addr", mem_addr, fill_addr);
                    end
                    wait_n++;
                end
            end
            @(negedge clk);
            mem_gnt = 0;
            #1;
            cyc++;
        end
        if (cyc >= 200) chk("access_timeout", 1'b0, 1'b1);
        @(negedge clk);
        rd_req = 0; wr_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 0; rst = 1; addr = 0; rd_req = 0; wr_req = 0; wr_be = 0; wr_data = 0;
        mem_gnt = 0; mem_rd_line = '0;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_miss", miss, 1'b0);
        chk("rst_mem_rd_req", mem_rd_req, 1'b0);
        chk("rst_mem_wr_req", mem_wr_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 9'h0);
        chk("rst_hit_cnt", hit_cnt, 32'h0);
        chk("rst_miss_cnt", miss_cnt, 32'h0);

        // Cold load of tag1/set0 word0.
        access(32'h100, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("t1_miss", first_miss, 1'b1);
        chk("t1_no_wb", wb_seen, 1'b0);
        chk("t1_fill_addr", fill_addr, 9'h008);
        chk("t1_rd_data", rd_data, 32'hD000_0800);

        // Byte-1 store, then read back the merged word.
        access(32'h104, 0, 1, 4'b0010, 32'hAABB_CCDD, 0, 0);
        chk("t2_store_hit", first_miss, 1'b0);
        access(32'h104, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("t2_load_hit", first_miss, 1'b0);
        chk("t2_rd_data", rd_data, 32'hD000_CC01);

        // Fill tags 0,2,3 into set0; tag1 (dirty, oldest) becomes the victim of tag5.
        access(32'h000, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("t4_fill_t0", fill_addr, 9'h000);
        access(32'h200, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("t4_fill_t2", fill_addr, 9'h010);
        access(32'h300, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("t4_fill_t3", fill_addr, 9'h018);
        chk("t4_fill_t3_no_wb", wb_seen, 1'b0);
        access(32'h50C, 1, 0, 4'h0, 32'h0, 0, 0);
        exp_line = line_of(9'h008);
        exp_line[63:32] = 32'hD000_CC01;
        chk("t4_wb_seen", wb_seen, 1'b1);
        chk("t4_wb_addr", wb_addr, 9'h008);
        chk("t4_wb_line", wb_line, exp_line);
        chk("t4_fill_addr", fill_addr, 9'h028);
        chk("t4_rd_data", rd_data, 32'hD000_2803);

        // LRU in set1: fill tags 0..3, touch tag0, tag4 must evict tag1.
        access(32'h020, 1, 0, 4'h0, 32'h0, 0, 0);
        access(32'h120, 1, 0, 4'h0, 32'h0, 0, 0);
        access(32'h220, 1, 0, 4'h0, 32'h0, 0, 0);
        access(32'h320, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("t3_fill_t3", fill_addr, 9'h019);
        access(32'h020, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("t3_touch_t0_hit", first_miss, 1'b0);
        access(32'h420, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("t3_t4_miss", first_miss, 1'b1);
        chk("t3_t4_no_wb", wb_seen, 1'b0);
        chk("t3_t4_fill_addr", fill_addr, 9'h021);
        chk("t3_t4_rd_data", rd_data, 32'hD000_2100);
        access(32'h020, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("t3_t0_kept", first_miss, 1'b0);
        access(32'h220, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("t3_t2_kept", first_miss, 1'b0);
        access(32'h320, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("t3_t3_kept", first_miss, 1'b0);
        access(32'h120, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("t3_t1_evicted", first_miss, 1'b1);

        // Grant delayed 10 cycles: request and address held, core stalled.
        access(32'h040, 1, 0, 4'h0, 32'h0, 10, 1);
        chk("t5_fill_addr", fill_addr, 9'h002);
        chk("t5_rd_data", rd_data, 32'hD000_0200);

        // Reset during an outstanding fill.
        @(negedge clk);
        addr = 32'h140; rd_req = 1;
        @(negedge clk);
        #1;
        chk("t5_in_fill", mem_rd_req, 1'b1);
        chk("t5_fill_req_addr", mem_addr, 9'h00A);
        @(negedge clk);
        #1 rst = 1;
        #1;
        chk("t5_rst_rd_req", mem_rd_req, 1'b0);
        chk("t5_rst_addr", mem_addr, 9'h0);
        chk("t5_rst_rd_data", rd_data, 32'h0);
        chk("t5_rst_miss", miss, 1'b1);
        rd_req = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("t5_idle_miss", miss, 1'b0);

        // A stray grant in IDLE must not start any transfer.
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        #1;
        chk("gnt_idle_rd_req", mem_rd_req, 1'b0);
        chk("gnt_idle_wr_req", mem_wr_req, 1'b0);

        // After reset every line is invalid; counters see 3 hit cycles and 2 misses.
        access(32'h040, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("t6_invalid_after_rst", first_miss, 1'b1);
        chk("t6_no_wb", wb_seen, 1'b0);
        access(32'h044, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("t6_hit", first_miss, 1'b0);
        chk("t6_rd_data_hit", rd_data, 32'hD000_0201);
        access(32'h060, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("t6_fill_addr", fill_addr, 9'h003);
        chk("t6_rd_data_fill", rd_data, 32'hD000_0300);
`ifdef DCACHE_PERF_CNT_EN
        exp_hits = 32'd3; exp_misses = 32'd2;
`else
        exp_hits = 32'd0; exp_misses = 32'd0;
`endif
        chk("t6_hit_cnt", hit_cnt, exp_hits);
        chk("t6_miss_cnt", miss_cnt, exp_misses);

        // Read+write together: write wins, rd_data holds.
        access(32'h044, 1, 1, 4'hF, 32'h1122_3344, 0, 0);
        chk("rw_hit", first_miss, 1'b0);
        chk("rw_rd_data_hold", rd_data, 32'hD000_0300);
        access(32'h044, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("rw_written", rd_data, 32'h1122_3344);

        // Store with no byte enables leaves the word unchanged.
        access(32'h044, 0, 1, 4'h0, 32'hFFFF_FFFF, 0, 0);
        chk("be0_hit", first_miss, 1'b0);
        access(32'h044, 1, 0, 4'h0, 32'h0, 0, 0);
        chk("be0_unchanged", rd_data, 32'h1122_3344);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
